// File: rtl/mem_access_ctrl.sv
// Load/store initiator: accepts one request, checks alignment and range,
// runs a single RAM access cycle and returns a registered response.
module mem_access_ctrl #(
    parameter int ADDR_WIDTH = 13
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic [1:0]  resp_exc,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [1:0]  mem_mask,
    output logic        mem_signed_ext,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic        lat_store;
    logic [1:0]  lat_size;
    logic        lat_unsigned;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;

    logic        misaligned;
    logic        out_of_range;
    logic        req_fault;
    logic        accept;

    assign misaligned   = ((req_size == 2'b01) && req_addr[0]) ||
                          (req_size[1] && (req_addr[1:0] != 2'b00));
    assign out_of_range = (req_addr >> ADDR_WIDTH) != 32'd0;
    assign req_fault    = misaligned || out_of_range;
    assign accept       = (state == IDLE) && req_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    state_nxt = req_fault ? RESP : ACCESS;
                end
            end
            ACCESS: state_nxt = RESP;
            RESP: begin
                if (resp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Request latch and response registers; a fault skips ACCESS and reports directly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_store    <= 1'b0;
            lat_size     <= 2'b00;
            lat_unsigned <= 1'b0;
            lat_addr     <= 32'd0;
            lat_wdata    <= 32'd0;
            resp_rdata   <= 32'd0;
            resp_exc     <= 2'b00;
        end else begin
            if (accept) begin
                lat_store    <= req_store;
                lat_size     <= req_size;
                lat_unsigned <= req_unsigned;
                lat_addr     <= req_addr;
                lat_wdata    <= req_wdata;
                if (req_fault) begin
                    resp_rdata <= 32'd0;
                    resp_exc   <= req_store ? 2'b10 : 2'b01;
                end
            end else if (state == ACCESS) begin
                resp_rdata <= lat_store ? 32'd0 : mem_rdata;
                resp_exc   <= 2'b00;
            end
        end
    end

    // mem_we is decoded from state so an asynchronous reset kills a pending write at once.
    assign req_ready      = (state == IDLE);
    assign resp_valid     = (state == RESP);
    assign mem_we         = (state == ACCESS) && lat_store;
    assign mem_addr       = lat_addr;
    assign mem_mask       = {lat_size[1], lat_size == 2'b01};
    assign mem_signed_ext = ~lat_unsigned;
    assign mem_wdata      = lat_wdata;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a little-endian byte-lane RAM model.
module tb_mem_access_ctrl;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_exc;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [1:0]  mem_mask;
    logic        mem_signed_ext;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;
    int we_cnt   = 0;

    logic [7:0]  ram [0:8191];
    logic [12:0] ra;
    logic [7:0]  b0, b1, b2, b3;

    mem_access_ctrl #(.ADDR_WIDTH(13)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_store      (req_store),
        .req_size       (req_size),
        .req_unsigned   (req_unsigned),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_rdata     (resp_rdata),
        .resp_exc       (resp_exc),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_mask       (mem_mask),
        .mem_signed_ext (mem_signed_ext),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM read: combinational, extended according to mask/sign select
    always_comb begin
        ra = mem_addr[12:0];
        b0 = ram[ra];
        b1 = ram[ra + 13'd1];
        b2 = ram[ra + 13'd2];
        b3 = ram[ra + 13'd3];
        mem_rdata = {b3, b2, b1, b0};
        if (mem_mask == 2'b00)
            mem_rdata = mem_signed_ext ? {{24{b0[7]}}, b0} : {24'd0, b0};
        else if (mem_mask == 2'b01)
            mem_rdata = mem_signed_ext ? {{16{b1[7]}}, b1, b0} : {16'd0, b1, b0};
    end

    always @(posedge clk) begin
        if (mem_we) begin
            ram[mem_addr[12:0]] <= mem_wdata[7:0];
            if (mem_mask != 2'b00)
                ram[mem_addr[12:0] + 13'd1] <= mem_wdata[15:8];
            if (mem_mask[1]) begin
                ram[mem_addr[12:0] + 13'd2] <= mem_wdata[23:16];
                ram[mem_addr[12:0] + 13'd3] <= mem_wdata[31:24];
            end
        end
    end

    always @(negedge clk) if (mem_we) we_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One transaction with resp_ready held high; checks ACCESS, RESP and return to IDLE.
    task automatic do_req(input string tag, input logic st, input logic [1:0] sz, input logic un,
                          input logic [31:0] ad, input logic [31:0] wd, input logic [1:0] exp_mask,
                          input logic [31:0] exp_rd, input logic [1:0] exp_exc);
        int we0;
        @(negedge clk);
        chk({tag, " req_ready idle"}, {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_store = st; req_size = sz; req_unsigned = un;
        req_addr = ad; req_wdata = wd;
        we0 = we_cnt;
        @(negedge clk);
        req_valid = 1'b0; req_addr = 32'hFFFF_FFFC; req_wdata = 32'h0BAD_F00D; req_store = ~st;
        if (exp_exc == 2'b00) begin
            chk({tag, " access resp_valid"}, {31'd0, resp_valid}, 32'd0);
            chk({tag, " access req_ready"}, {31'd0, req_ready}, 32'd0);
            chk({tag, " access mem_we"}, {31'd0, mem_we}, {31'd0, st});
            chk({tag, " access mem_mask"}, {30'd0, mem_mask}, {30'd0, exp_mask});
            chk({tag, " access mem_addr"}, mem_addr, ad);
            chk({tag, " access signed_ext"}, {31'd0, mem_signed_ext}, {31'd0, ~un});
            @(negedge clk);
        end
        chk({tag, " resp_valid"}, {31'd0, resp_valid}, 32'd1);
        chk({tag, " resp_rdata"}, resp_rdata, exp_rd);
        chk({tag, " resp_exc"}, {30'd0, resp_exc}, {30'd0, exp_exc});
        chk({tag, " resp req_ready"}, {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        chk({tag, " back to idle"}, {30'd0, resp_valid, req_ready}, 32'd1);
        chk({tag, " we cycles"}, we_cnt - we0, (st && exp_exc == 2'b00) ? 32'd1 : 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) ram[i] = 8'h00;
        ram[0] = 8'h56; ram[1] = 8'h34; ram[2] = 8'h12; ram[3] = 8'h80;
        for (int i = 32; i < 36; i++) ram[i] = 8'hA5;

        rst = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0; resp_ready = 1'b1;
        #1;
        chk("reset req_ready", {31'd0, req_ready}, 32'd1);
        chk("reset resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("reset resp_rdata", resp_rdata, 32'd0);
        chk("reset resp_exc", {30'd0, resp_exc}, 32'd0);
        chk("reset mem_we", {31'd0, mem_we}, 32'd0);
        chk("reset mem_addr", mem_addr, 32'd0);
        chk("reset mem_wdata", mem_wdata, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        do_req("LB 3",     1'b0, 2'b00, 1'b0, 32'h3,  32'h0, 2'b00, 32'hFFFF_FF80, 2'b00);
        do_req("LBU 3",    1'b0, 2'b00, 1'b1, 32'h3,  32'h0, 2'b00, 32'h0000_0080, 2'b00);
        do_req("LHU 2",    1'b0, 2'b01, 1'b1, 32'h2,  32'h0, 2'b01, 32'h0000_8012, 2'b00);
        do_req("LH 0",     1'b0, 2'b01, 1'b0, 32'h0,  32'h0, 2'b01, 32'h0000_3456, 2'b00);
        do_req("SW 10",    1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, 2'b10, 32'h0, 2'b00);
        do_req("SB 11",    1'b1, 2'b00, 1'b0, 32'h11, 32'h0000_0055, 2'b00, 32'h0, 2'b00);
        do_req("LW 10",    1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 2'b10, 32'hDEAD_55EF, 2'b00);
        do_req("SH 5",     1'b1, 2'b01, 1'b0, 32'h5,  32'h1234, 2'b01, 32'h0, 2'b10);
        do_req("LW 2002",  1'b0, 2'b10, 1'b0, 32'h2002, 32'h0, 2'b10, 32'h0, 2'b01);
        do_req("LW 2000",  1'b0, 2'b10, 1'b0, 32'h2000, 32'h0, 2'b10, 32'h0, 2'b01);
        do_req("LH 1",     1'b0, 2'b01, 1'b0, 32'h1,  32'h0, 2'b01, 32'h0, 2'b01);
        do_req("SW 1FFC",  1'b1, 2'b10, 1'b0, 32'h1FFC, 32'hCAFE_0001, 2'b10, 32'h0, 2'b00);
        do_req("LW11 1FFC", 1'b0, 2'b11, 1'b0, 32'h1FFC, 32'h0, 2'b10, 32'hCAFE_0001, 2'b00);

        // Backpressure: response must hold while resp_ready is low
        @(negedge clk);
        resp_ready = 1'b0;
        req_valid = 1'b1; req_store = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 32'h10; req_wdata = 32'h0;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("bp first resp_valid", {31'd0, resp_valid}, 32'd1);
        chk("bp first rdata", resp_rdata, 32'hDEAD_55EF);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp resp_valid", {31'd0, resp_valid}, 32'd1);
            chk("bp rdata", resp_rdata, 32'hDEAD_55EF);
            chk("bp exc", {30'd0, resp_exc}, 32'd0);
            chk("bp req_ready", {31'd0, req_ready}, 32'd0);
            chk("bp mem_we", {31'd0, mem_we}, 32'd0);
            if (i == 1) begin
                req_valid = 1'b1; req_store = 1'b1; req_size = 2'b10;
                req_addr = 32'h10; req_wdata = 32'h1111_2222;
            end else begin
                req_valid = 1'b0;
            end
        end
        resp_ready = 1'b1;
        @(negedge clk);
        chk("bp released", {30'd0, resp_valid, req_ready}, 32'd1);
        do_req("LW 10 after bp", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 2'b10, 32'hDEAD_55EF, 2'b00);

        // Reset in the middle of a store's ACCESS cycle
        @(negedge clk);
        req_valid = 1'b1; req_store = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 32'h20; req_wdata = 32'h1234_5678;
        @(posedge clk);
        #2;
        req_valid = 1'b0;
        chk("rst store mem_we before", {31'd0, mem_we}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rst mem_we dropped", {31'd0, mem_we}, 32'd0);
        chk("rst req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst resp_rdata", resp_rdata, 32'd0);
        chk("rst resp_exc", {30'd0, resp_exc}, 32'd0);
        chk("rst mem_addr", mem_addr, 32'd0);
        chk("rst mem_wdata", mem_wdata, 32'd0);
        chk("rst mem_mask", {30'd0, mem_mask}, 32'd0);
        chk("rst signed_ext", {31'd0, mem_signed_ext}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        do_req("LW 20 after rst", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 2'b10, 32'hA5A5_A5A5, 2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
